// File: rtl/sc_counter_lives_levels_if.sv
`default_nettype none
// ============================================================================
// Module   : sc_counter_lives_levels_if
// Brief    : Strobe/status bundle between the game FSM and the lives/levels
//            counter block.
// Revision : 1.0 - initial release
// ============================================================================
interface sc_counter_lives_levels_if #(
  parameter int DATAWIDTH = 4
);
  // Active-low request strobes from the game FSM
  logic                 SC_COUNTERLIVESLEVELS_clear_InLow;
  logic                 SC_COUNTERLIVESLEVELS_contador_vidas_InLow;
  logic                 SC_COUNTERLIVESLEVELS_contador_niveles_InLow;
  // Counter values and decoded flags back to the FSM / display
  logic [DATAWIDTH-1:0] SC_COUNTERLIVESLEVELS_lives_Out;
  logic [DATAWIDTH-1:0] SC_COUNTERLIVESLEVELS_level_Out;
  logic                 SC_COUNTERLIVESLEVELS_COMPARATOR_LIVES;
  logic                 SC_COUNTERLIVESLEVELS_COMPARATOR_LEVELS;

  modport master (
    output SC_COUNTERLIVESLEVELS_clear_InLow,
    output SC_COUNTERLIVESLEVELS_contador_vidas_InLow,
    output SC_COUNTERLIVESLEVELS_contador_niveles_InLow,
    input  SC_COUNTERLIVESLEVELS_lives_Out,
    input  SC_COUNTERLIVESLEVELS_level_Out,
    input  SC_COUNTERLIVESLEVELS_COMPARATOR_LIVES,
    input  SC_COUNTERLIVESLEVELS_COMPARATOR_LEVELS
  );

  modport slave (
    input  SC_COUNTERLIVESLEVELS_clear_InLow,
    input  SC_COUNTERLIVESLEVELS_contador_vidas_InLow,
    input  SC_COUNTERLIVESLEVELS_contador_niveles_InLow,
    output SC_COUNTERLIVESLEVELS_lives_Out,
    output SC_COUNTERLIVESLEVELS_level_Out,
    output SC_COUNTERLIVESLEVELS_COMPARATOR_LIVES,
    output SC_COUNTERLIVESLEVELS_COMPARATOR_LEVELS
  );
endinterface
`default_nettype wire

// File: rtl/sc_counter_lives_levels.sv
`default_nettype none
// ============================================================================
// Module   : sc_counter_lives_levels
// Brief    : Remaining-lives and current-level counters driven by active-low
//            strobes from the Frogger game FSM, with win/lose decode flags.
// Revision : 1.0 - initial release
// ============================================================================
module sc_counter_lives_levels #(
  parameter int DATAWIDTH     = 4,
  parameter int INITIAL_LIVES = 3,
  parameter int MAX_LEVELS    = 4
) (
  input  wire logic                     SC_COUNTERLIVESLEVELS_CLOCK_50,
  input  wire logic                     SC_COUNTERLIVESLEVELS_RESET_InHigh,
  sc_counter_lives_levels_if.slave      cnt_bus
);

  localparam logic [DATAWIDTH-1:0] C_INIT_LIVES = DATAWIDTH'(INITIAL_LIVES);
  localparam logic [DATAWIDTH-1:0] C_MAX_LEVELS = DATAWIDTH'(MAX_LEVELS);
  localparam logic [DATAWIDTH-1:0] C_ZERO       = '0;
  localparam logic [DATAWIDTH-1:0] C_ONE        = DATAWIDTH'(1);

  logic                 vidas_prev_q;
  logic                 niveles_prev_q;
  logic [DATAWIDTH-1:0] lives_q;
  logic [DATAWIDTH-1:0] lives_d;
  logic [DATAWIDTH-1:0] level_q;
  logic [DATAWIDTH-1:0] level_d;

  logic                 vidas_evt_w;
  logic                 niveles_evt_w;

  // A strobe counts once per 1->0 transition, however long it is held low
  assign vidas_evt_w   = vidas_prev_q   & ~cnt_bus.SC_COUNTERLIVESLEVELS_contador_vidas_InLow;
  assign niveles_evt_w = niveles_prev_q & ~cnt_bus.SC_COUNTERLIVESLEVELS_contador_niveles_InLow;

  always_comb begin
    lives_d = lives_q;
    level_d = level_q;
    if (!cnt_bus.SC_COUNTERLIVESLEVELS_clear_InLow) begin
      // Clear wins; any event in the same cycle is dropped, not deferred
      lives_d = C_INIT_LIVES;
      level_d = C_ZERO;
    end else begin
      if (vidas_evt_w && (lives_q != C_ZERO)) begin
        lives_d = lives_q - C_ONE;
      end
      if (niveles_evt_w && (level_q < C_MAX_LEVELS)) begin
        level_d = level_q + C_ONE;
      end
    end
  end

  always_ff @(posedge SC_COUNTERLIVESLEVELS_CLOCK_50 or posedge SC_COUNTERLIVESLEVELS_RESET_InHigh) begin
    if (SC_COUNTERLIVESLEVELS_RESET_InHigh) begin
      vidas_prev_q   <= 1'b1;
      niveles_prev_q <= 1'b1;
      lives_q        <= C_INIT_LIVES;
      level_q        <= C_ZERO;
    end else begin
      vidas_prev_q   <= cnt_bus.SC_COUNTERLIVESLEVELS_contador_vidas_InLow;
      niveles_prev_q <= cnt_bus.SC_COUNTERLIVESLEVELS_contador_niveles_InLow;
      lives_q        <= lives_d;
      level_q        <= level_d;
    end
  end

  assign cnt_bus.SC_COUNTERLIVESLEVELS_lives_Out         = lives_q;
  assign cnt_bus.SC_COUNTERLIVESLEVELS_level_Out         = level_q;
  assign cnt_bus.SC_COUNTERLIVESLEVELS_COMPARATOR_LIVES  = (lives_q == C_ZERO);
  assign cnt_bus.SC_COUNTERLIVESLEVELS_COMPARATOR_LEVELS = ~(level_q == C_MAX_LEVELS);

endmodule
`default_nettype wire

// File: tb/tb_sc_counter_lives_levels.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_counter_lives_levels
// Brief    : Directed self-checking bench for the lives/levels counter block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_counter_lives_levels;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fail;

  sc_counter_lives_levels_if #(.DATAWIDTH(4)) bus_if ();

  sc_counter_lives_levels #(
    .DATAWIDTH     (4),
    .INITIAL_LIVES (3),
    .MAX_LEVELS    (4)
  ) dut (
    .SC_COUNTERLIVESLEVELS_CLOCK_50     (clk),
    .SC_COUNTERLIVESLEVELS_RESET_InHigh (rst),
    .cnt_bus                            (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] lv, input logic [3:0] lvl,
                         input logic cl, input logic cv);
    chk({tag, ".lives"}, {4'd0, bus_if.SC_COUNTERLIVESLEVELS_lives_Out}, {4'd0, lv});
    chk({tag, ".level"}, {4'd0, bus_if.SC_COUNTERLIVESLEVELS_level_Out}, {4'd0, lvl});
    chk({tag, ".cmp_lives"}, {7'd0, bus_if.SC_COUNTERLIVESLEVELS_COMPARATOR_LIVES}, {7'd0, cl});
    chk({tag, ".cmp_levels"}, {7'd0, bus_if.SC_COUNTERLIVESLEVELS_COMPARATOR_LEVELS}, {7'd0, cv});
  endtask

  task automatic do_clear();
    bus_if.SC_COUNTERLIVESLEVELS_clear_InLow = 1'b0;
    tick();
    bus_if.SC_COUNTERLIVESLEVELS_clear_InLow = 1'b1;
  endtask

  task automatic pulse_vidas();
    bus_if.SC_COUNTERLIVESLEVELS_contador_vidas_InLow = 1'b0;
    tick();
    bus_if.SC_COUNTERLIVESLEVELS_contador_vidas_InLow = 1'b1;
  endtask

  task automatic pulse_niveles();
    bus_if.SC_COUNTERLIVESLEVELS_contador_niveles_InLow = 1'b0;
    tick();
    bus_if.SC_COUNTERLIVESLEVELS_contador_niveles_InLow = 1'b1;
  endtask

  logic [3:0] exp_lives [4];
  logic [3:0] exp_level [5];

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    exp_lives = '{4'd2, 4'd1, 4'd0, 4'd0};
    exp_level = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4};

    rst = 1'b1;
    bus_if.SC_COUNTERLIVESLEVELS_clear_InLow          = 1'b1;
    bus_if.SC_COUNTERLIVESLEVELS_contador_vidas_InLow   = 1'b1;
    bus_if.SC_COUNTERLIVESLEVELS_contador_niveles_InLow = 1'b1;

    // Reset applied before any clock edge
    #3;
    chk_all("reset", 4'd3, 4'd0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    chk_all("post_reset", 4'd3, 4'd0, 1'b0, 1'b1);

    // Lives depletion with saturation at zero
    for (int i = 0; i < 4; i++) begin
      pulse_vidas();
      chk($sformatf("deplete%0d.lives", i), {4'd0, bus_if.SC_COUNTERLIVESLEVELS_lives_Out}, {4'd0, exp_lives[i]});
      chk($sformatf("deplete%0d.cmp_lives", i), {7'd0, bus_if.SC_COUNTERLIVESLEVELS_COMPARATOR_LIVES},
          (i >= 2) ? 8'd1 : 8'd0);
      tick();
    end

    // Held strobe counts once
    do_clear();
    tick();
    chk_all("after_clear", 4'd3, 4'd0, 1'b0, 1'b1);
    bus_if.SC_COUNTERLIVESLEVELS_contador_vidas_InLow = 1'b0;
    repeat (10) tick();
    chk("held.lives", {4'd0, bus_if.SC_COUNTERLIVESLEVELS_lives_Out}, 8'd2);
    bus_if.SC_COUNTERLIVESLEVELS_contador_vidas_InLow = 1'b1;
    tick();
    pulse_vidas();
    chk("held_next.lives", {4'd0, bus_if.SC_COUNTERLIVESLEVELS_lives_Out}, 8'd1);
    tick();

    // Level win with saturation at MAX_LEVELS
    do_clear();
    tick();
    for (int i = 0; i < 5; i++) begin
      pulse_niveles();
      chk($sformatf("level%0d.level", i), {4'd0, bus_if.SC_COUNTERLIVESLEVELS_level_Out}, {4'd0, exp_level[i]});
      chk($sformatf("level%0d.cmp_levels", i), {7'd0, bus_if.SC_COUNTERLIVESLEVELS_COMPARATOR_LEVELS},
          (i >= 3) ? 8'd0 : 8'd1);
      tick();
    end

    // Clear beats a coincident vidas edge, and the edge is consumed
    do_clear();
    tick();
    pulse_vidas();  tick();
    pulse_vidas();  tick();
    pulse_niveles(); tick();
    pulse_niveles(); tick();
    chk_all("pre_clear", 4'd1, 4'd2, 1'b0, 1'b1);
    bus_if.SC_COUNTERLIVESLEVELS_clear_InLow          = 1'b0;
    bus_if.SC_COUNTERLIVESLEVELS_contador_vidas_InLow = 1'b0;
    tick();
    chk_all("clear_prio", 4'd3, 4'd0, 1'b0, 1'b1);
    bus_if.SC_COUNTERLIVESLEVELS_clear_InLow = 1'b1;
    tick();
    chk("consumed1.lives", {4'd0, bus_if.SC_COUNTERLIVESLEVELS_lives_Out}, 8'd3);
    tick();
    chk("consumed2.lives", {4'd0, bus_if.SC_COUNTERLIVESLEVELS_lives_Out}, 8'd3);
    bus_if.SC_COUNTERLIVESLEVELS_contador_vidas_InLow = 1'b1;
    tick();
    pulse_vidas();
    chk("new_edge.lives", {4'd0, bus_if.SC_COUNTERLIVESLEVELS_lives_Out}, 8'd2);
    tick();

    // Simultaneous events, then async reset between edges
    do_clear();
    tick();
    bus_if.SC_COUNTERLIVESLEVELS_contador_vidas_InLow   = 1'b0;
    bus_if.SC_COUNTERLIVESLEVELS_contador_niveles_InLow = 1'b0;
    tick();
    chk_all("simul", 4'd2, 4'd1, 1'b0, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_reset", 4'd3, 4'd0, 1'b0, 1'b1);
    bus_if.SC_COUNTERLIVESLEVELS_contador_vidas_InLow   = 1'b1;
    bus_if.SC_COUNTERLIVESLEVELS_contador_niveles_InLow = 1'b1;
    tick();
    chk_all("reset_hold", 4'd3, 4'd0, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    pulse_vidas();
    chk("post_rst.lives", {4'd0, bus_if.SC_COUNTERLIVESLEVELS_lives_Out}, 8'd2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
